// File: rtl/booth_pp_accum_pkg.sv
// Shared types and constants for the multi-cycle radix-4 Booth partial-product accumulator.
// Imported by the interface, the pair adder and the top level.
package booth_pp_accum_pkg;

  localparam int NUM_PP      = 8;
  localparam int PP_W        = 32;
  localparam int PP_PER_STEP = 2;
  localparam int ACC_STEPS   = NUM_PP / PP_PER_STEP;
  localparam int STEP_W      = 2;
  localparam int SHIFT_W     = 5;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_STEPS - 1);

  typedef logic [PP_W-1:0] pp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_pp_accum_if.sv
// Partial-product input bus and product output bus, each with a valid/ready handshake.
// master = producer/consumer side, slave = accumulator side.
interface booth_pp_accum_if;
  import booth_pp_accum_pkg::*;

  logic in_valid;
  logic in_ready;
  pp_t  pp_0;
  pp_t  pp_1;
  pp_t  pp_2;
  pp_t  pp_3;
  pp_t  pp_4;
  pp_t  pp_5;
  pp_t  pp_6;
  pp_t  pp_7;
  logic out_valid;
  logic out_ready;
  pp_t  out_data;

  modport master (
    output in_valid, pp_0, pp_1, pp_2, pp_3, pp_4, pp_5, pp_6, pp_7, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, pp_0, pp_1, pp_2, pp_3, pp_4, pp_5, pp_6, pp_7, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/booth_pp_accum_pp_pair_add.sv
// Combinational step adder: folds one even/odd partial-product pair into the accumulator.
// Pair k=2*step lands at weight 4^(2*step) = 2^(4*step); its odd partner sits two bits higher.
module booth_pp_accum_pp_pair_add
  import booth_pp_accum_pkg::*;
(
  input  pp_t               acc,
  input  pp_t               pp_even,
  input  pp_t               pp_odd,
  input  logic [STEP_W-1:0] step,
  output pp_t               sum
);

  logic [SHIFT_W-1:0] shift_even;
  logic [SHIFT_W-1:0] shift_odd;

  always_comb begin
    shift_even = {1'b0, step, 2'b00};
    shift_odd  = shift_even + SHIFT_W'(2);
  end

  // Bits pushed past bit 31 and the final carry are dropped: modulo-2^32 sum.
  assign sum = acc + (pp_even << shift_even) + (pp_odd << shift_odd);

endmodule

// File: rtl/booth_pp_accum.sv
// Captures eight Booth partial products, sums them two per cycle over four cycles,
// then holds the 32-bit product on a valid/ready output until accepted.
module booth_pp_accum
  import booth_pp_accum_pkg::*;
(
  input logic             clk,
  input logic             rst,
  booth_pp_accum_if.slave bus
);

  state_t            state_reg;
  logic [STEP_W-1:0] step_reg;
  pp_t               acc_reg;
  pp_t               pp_reg [NUM_PP];
  logic              in_ready_reg;
  logic              out_valid_reg;

  pp_t  pp_in [NUM_PP];
  pp_t  pp_even;
  pp_t  pp_odd;
  pp_t  acc_next;
  logic accept;

  assign pp_in[0] = bus.pp_0;
  assign pp_in[1] = bus.pp_1;
  assign pp_in[2] = bus.pp_2;
  assign pp_in[3] = bus.pp_3;
  assign pp_in[4] = bus.pp_4;
  assign pp_in[5] = bus.pp_5;
  assign pp_in[6] = bus.pp_6;
  assign pp_in[7] = bus.pp_7;

  // in_ready_reg is high exactly in IDLE, so this is the IDLE-state accept.
  assign accept = bus.in_valid && in_ready_reg;

  generate
    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_capture
      always_ff @(posedge clk) begin
        if (rst) begin
          pp_reg[gi] <= '0;
        end else if (accept) begin
          pp_reg[gi] <= pp_in[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    pp_even = pp_reg[{step_reg, 1'b0}];
    pp_odd  = pp_reg[{step_reg, 1'b1}];
  end

  booth_pp_accum_pp_pair_add u_pp_pair_add (
    .acc     (acc_reg),
    .pp_even (pp_even),
    .pp_odd  (pp_odd),
    .step    (step_reg),
    .sum     (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg      <= '0;
            step_reg     <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ACC;
          end
        end
        ACC: begin
          acc_reg  <= acc_next;
          step_reg <= step_reg + STEP_W'(1);
          if (step_reg == LAST_STEP) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          step_reg      <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = acc_reg;

endmodule
